xbar_st_stage: RTL and testbench

- Switch-traversal stage directly downstream of the port allocator.
- Consumes the per-input one-hot allocation vectors and the input flits, drives them through a NUM_PORT x NUM_PORT crossbar, and registers the result into the output link latches.
- Also flags allocation faults: dropped flits, output collisions and multi-hot grants.
- Keeps saturating per-output flit counters for statistics.

---
 rtl/xbar_st_stage_if.sv | 28 ++
 rtl/xbar_st_stage.sv | 120 ++++++++++++
 tb/tb_xbar_st_stage.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xbar_st_stage_if.sv
// Handshake/bus bundle for the switch-traversal stage.
// master = allocator/link side driving flits and grants, slave = the stage itself.
interface xbar_st_stage_if #(
    parameter int NUM_PORT = 5,
    parameter int FLIT_W   = 64,
    parameter int CNT_W    = 16
);
    logic [NUM_PORT*FLIT_W-1:0]   flitInVector;
    logic [NUM_PORT-1:0]          validInVector;
    logic [NUM_PORT*NUM_PORT-1:0] allocVector;
    logic                         stall;
    logic                         clearStats;
    logic [NUM_PORT*FLIT_W-1:0]   flitOutVector;
    logic [NUM_PORT-1:0]          validOutVector;
    logic [NUM_PORT-1:0]          dropVector;
    logic                         allocErr;
    logic [NUM_PORT*CNT_W-1:0]    flitCountVector;

    modport master (
        output flitInVector, validInVector, allocVector, stall, clearStats,
        input  flitOutVector, validOutVector, dropVector, allocErr, flitCountVector
    );

    modport slave (
        input  flitInVector, validInVector, allocVector, stall, clearStats,
        output flitOutVector, validOutVector, dropVector, allocErr, flitCountVector
    );
endinterface

// File: rtl/xbar_st_stage.sv
// Switch-traversal stage: NUM_PORT x NUM_PORT crossbar into registered output
// latches, with allocation fault detection and saturating per-output counters.
module xbar_st_stage #(
    parameter int NUM_PORT = 5,
    parameter int FLIT_W   = 64,
    parameter int CNT_W    = 16
) (
    input logic          clk,
    input logic          reset,
    xbar_st_stage_if.slave bus
);

    logic [NUM_PORT-1:0] masked    [NUM_PORT];
    logic [NUM_PORT-1:0] eff       [NUM_PORT];
    logic [FLIT_W-1:0]   win_flit  [NUM_PORT];
    logic [NUM_PORT-1:0] hit;
    logic [NUM_PORT-1:0] delivered;
    logic [NUM_PORT-1:0] drop_now;
    logic                multi_any;
    logic                collision;
    logic                err_now;

    logic [FLIT_W-1:0]   flit_q [NUM_PORT];
    logic [FLIT_W-1:0]   flit_d [NUM_PORT];
    logic [CNT_W-1:0]    cnt_q  [NUM_PORT];
    logic [CNT_W-1:0]    cnt_d  [NUM_PORT];
    logic [NUM_PORT-1:0] valid_q, valid_d;
    logic [NUM_PORT-1:0] drop_q, drop_d;
    logic                err_q, err_d;

    // Mask grants by input validity and keep only the lowest granted output.
    always_comb begin
        multi_any = 1'b0;
        for (int i = 0; i < NUM_PORT; i++) begin
            masked[i] = bus.allocVector[i*NUM_PORT +: NUM_PORT]
                        & {NUM_PORT{bus.validInVector[i]}};
            eff[i]    = masked[i] & (~masked[i] + NUM_PORT'(1));
            if ((masked[i] & (masked[i] - NUM_PORT'(1))) != '0)
                multi_any = 1'b1;
        end
    end

    // Per-output arbitration: the lowest-index candidate input wins; any
    // further candidate is a collision and its flit goes undelivered.
    always_comb begin
        hit       = '0;
        delivered = '0;
        collision = 1'b0;
        for (int j = 0; j < NUM_PORT; j++) begin
            win_flit[j] = flit_q[j];
            for (int i = 0; i < NUM_PORT; i++) begin
                if (eff[i][j]) begin
                    if (!hit[j]) begin
                        hit[j]       = 1'b1;
                        win_flit[j]  = bus.flitInVector[i*FLIT_W +: FLIT_W];
                        delivered[i] = 1'b1;
                    end else begin
                        collision = 1'b1;
                    end
                end
            end
        end
        drop_now = bus.validInVector & ~delivered;
        err_now  = collision | multi_any | (|drop_now);
    end

    // Next-state for datapath, statistics and the sticky fault flag.
    // clearStats is evaluated last so it overrides a same-cycle increment or error.
    always_comb begin
        flit_d  = flit_q;
        valid_d = valid_q;
        drop_d  = '0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (!bus.stall) begin
            flit_d  = win_flit;
            valid_d = hit;
            drop_d  = drop_now;
            err_d   = err_q | err_now;
            for (int j = 0; j < NUM_PORT; j++) begin
                if (hit[j] && (cnt_q[j] != {CNT_W{1'b1}}))
                    cnt_d[j] = cnt_q[j] + CNT_W'(1);
            end
        end
        if (bus.clearStats) begin
            err_d = 1'b0;
            for (int j = 0; j < NUM_PORT; j++)
                cnt_d[j] = '0;
        end
    end

    // State registers; everything clears asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NUM_PORT; j++) begin
                flit_q[j] <= '0;
                cnt_q[j]  <= '0;
            end
            valid_q <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            flit_q  <= flit_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    for (genvar j = 0; j < NUM_PORT; j++) begin : g_out
        assign bus.flitOutVector[j*FLIT_W +: FLIT_W]  = flit_q[j];
        assign bus.flitCountVector[j*CNT_W +: CNT_W] = cnt_q[j];
    end

    assign bus.validOutVector = valid_q;
    assign bus.dropVector     = drop_q;
    assign bus.allocErr       = err_q;

endmodule

// File: tb/tb_xbar_st_stage.sv
// Self-checking bench for xbar_st_stage: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_xbar_st_stage;
    localparam int N    = 5;
    localparam int FW   = 64;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    xbar_st_stage_if #(.NUM_PORT(N), .FLIT_W(FW), .CNT_W(CW)) bus ();

    xbar_st_stage #(.NUM_PORT(N), .FLIT_W(FW), .CNT_W(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [FW-1:0] m_flit [N];
    logic [N-1:0]  m_valid;
    logic [N-1:0]  m_drop;
    logic          m_err;
    int            m_cnt  [N];

    // Model scratch
    int            winner [N];
    logic [N-1:0]  a_sl;
    int            tgt;
    bit            fault;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] out_flit(input int j);
        return bus.flitOutVector[j*FW +: FW];
    endfunction

    function automatic logic [CW-1:0] out_cnt(input int j);
        return bus.flitCountVector[j*CW +: CW];
    endfunction

    // Model: each valid input targets its lowest granted output; the first
    // input (by index) to claim an output gets it, anyone else is dropped.
    initial begin
        for (int j = 0; j < N; j++) begin
            m_flit[j] = '0;
            m_cnt[j]  = 0;
        end
        m_valid = '0; m_drop = '0; m_err = 1'b0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < N; j++) begin
                m_flit[j] = '0;
                m_cnt[j]  = 0;
            end
            m_valid = '0; m_drop = '0; m_err = 1'b0;
        end else begin
            if (!bus.stall) begin
                fault = 1'b0;
                for (int j = 0; j < N; j++) winner[j] = -1;
                m_drop = '0;
                for (int i = 0; i < N; i++) begin
                    if (bus.validInVector[i]) begin
                        a_sl = bus.allocVector[i*N +: N];
                        if ($countones(a_sl) > 1) fault = 1'b1;
                        tgt = -1;
                        for (int j = 0; j < N; j++)
                            if (a_sl[j] && tgt < 0) tgt = j;
                        if (tgt >= 0 && winner[tgt] < 0) winner[tgt] = i;
                        else begin
                            m_drop[i] = 1'b1;
                            fault     = 1'b1;
                        end
                    end
                end
                for (int j = 0; j < N; j++) begin
                    if (winner[j] >= 0) begin
                        m_flit[j]  = bus.flitInVector[winner[j]*FW +: FW];
                        m_valid[j] = 1'b1;
                        if (m_cnt[j] < CMAX) m_cnt[j] = m_cnt[j] + 1;
                    end else begin
                        m_valid[j] = 1'b0;
                    end
                end
                if (fault) m_err = 1'b1;
            end else begin
                m_drop = '0;
            end
            if (bus.clearStats) begin
                for (int j = 0; j < N; j++) m_cnt[j] = 0;
                m_err = 1'b0;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < N; j++) begin
                check($sformatf("model_flit%0d", j), out_flit(j), m_flit[j]);
                check($sformatf("model_cnt%0d", j), out_cnt(j), m_cnt[j]);
            end
            check("model_validOut", bus.validOutVector, m_valid);
            check("model_drop", bus.dropVector, m_drop);
            check("model_allocErr", bus.allocErr, m_err);
        end
    end

    task automatic idle();
        bus.validInVector = '0;
        bus.allocVector   = '0;
        bus.stall         = 1'b0;
        bus.clearStats    = 1'b0;
    endtask

    task automatic set_in(input int i, input bit v, input logic [N-1:0] a, input logic [FW-1:0] f);
        bus.validInVector[i]        = v;
        bus.allocVector[i*N +: N]   = a;
        bus.flitInVector[i*FW +: FW] = f;
    endtask

    initial begin
        bus.flitInVector = '0;
        idle();
        reset  = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Idle after reset
        check("rst_validOut", bus.validOutVector, 5'b00000);
        check("rst_drop", bus.dropVector, 5'b00000);
        check("rst_allocErr", bus.allocErr, 1'b0);
        for (int j = 0; j < N; j++) check($sformatf("rst_cnt%0d", j), out_cnt(j), 0);

        // Full permutation
        set_in(0, 1, 5'b00001, 64'hA0);
        set_in(1, 1, 5'b00010, 64'hA1);
        set_in(2, 1, 5'b01000, 64'hA2);
        set_in(3, 1, 5'b10000, 64'hA3);
        set_in(4, 1, 5'b00100, 64'hA4);
        @(negedge clk);
        check("perm_out0", out_flit(0), 64'hA0);
        check("perm_out1", out_flit(1), 64'hA1);
        check("perm_out2", out_flit(2), 64'hA4);
        check("perm_out3", out_flit(3), 64'hA2);
        check("perm_out4", out_flit(4), 64'hA3);
        check("perm_validOut", bus.validOutVector, 5'b11111);
        check("perm_drop", bus.dropVector, 5'b00000);
        check("perm_allocErr", bus.allocErr, 1'b0);
        for (int j = 0; j < N; j++) check($sformatf("perm_cnt%0d", j), out_cnt(j), 1);

        // Collision on output 0
        idle();
        set_in(0, 1, 5'b00001, 64'h11);
        set_in(1, 1, 5'b00001, 64'h22);
        @(negedge clk);
        check("coll_out0", out_flit(0), 64'h11);
        check("coll_valid0", bus.validOutVector[0], 1'b1);
        check("coll_drop", bus.dropVector, 5'b00010);
        check("coll_allocErr", bus.allocErr, 1'b1);
        idle();
        @(negedge clk);
        check("coll_sticky", bus.allocErr, 1'b1);
        check("coll_drop_clear", bus.dropVector, 5'b00000);

        // Multi-hot grant, then clearStats
        set_in(2, 1, 5'b01001, 64'h33);
        @(negedge clk);
        check("mh_out0", out_flit(0), 64'h33);
        check("mh_validOut", bus.validOutVector, 5'b00001);
        check("mh_allocErr", bus.allocErr, 1'b1);
        idle();
        bus.clearStats = 1'b1;
        @(negedge clk);
        bus.clearStats = 1'b0;
        check("clr_allocErr", bus.allocErr, 1'b0);
        for (int j = 0; j < N; j++) check($sformatf("clr_cnt%0d", j), out_cnt(j), 0);

        // Stall holds outputs and suppresses drops
        set_in(0, 1, 5'b01000, 64'h44);
        @(negedge clk);
        check("stl_pre_out3", out_flit(3), 64'h44);
        check("stl_pre_cnt3", out_cnt(3), 1);
        bus.stall = 1'b1;
        set_in(0, 1, 5'b01000, 64'h55);
        set_in(1, 1, 5'b00100, 64'h66);
        set_in(2, 1, 5'b00000, 64'h77);
        repeat (3) begin
            @(negedge clk);
            check("stl_out3", out_flit(3), 64'h44);
            check("stl_validOut", bus.validOutVector, 5'b01000);
            check("stl_cnt3", out_cnt(3), 1);
            check("stl_cnt2", out_cnt(2), 0);
            check("stl_drop", bus.dropVector, 5'b00000);
        end
        bus.stall = 1'b0;
        @(negedge clk);
        check("rel_out3", out_flit(3), 64'h55);
        check("rel_out2", out_flit(2), 64'h66);
        check("rel_validOut", bus.validOutVector, 5'b01100);
        check("rel_drop", bus.dropVector, 5'b00100);
        check("rel_cnt3", out_cnt(3), 2);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                int r;
                logic [N-1:0] a;
                r = $urandom_range(0, 9);
                if (r < 6)       a = N'(1) << $urandom_range(0, N-1);
                else if (r == 6) a = '0;
                else             a = N'($urandom_range(0, (1 << N) - 1));
                set_in(i, ($urandom_range(0, 3) != 0), a, {$urandom, $urandom});
            end
            bus.stall      = ($urandom_range(0, 9) == 0);
            bus.clearStats = ($urandom_range(0, 29) == 0);
            @(negedge clk);
        end

        // Saturate counter 1
        idle();
        for (int c = 0; c < 65540; c++) begin
            set_in(0, 1, 5'b00010, {$urandom, $urandom});
            @(negedge clk);
        end
        check("sat_cnt1", out_cnt(1), 16'hFFFF);
        check("sat_valid1", bus.validOutVector[1], 1'b1);

        // Asynchronous reset between edges
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_flitOut", bus.flitOutVector[63:0] | bus.flitOutVector[FW +: FW], 64'h0);
        check("arst_validOut", bus.validOutVector, 5'b00000);
        check("arst_drop", bus.dropVector, 5'b00000);
        check("arst_allocErr", bus.allocErr, 1'b0);
        check("arst_cnt1", out_cnt(1), 0);
        check("arst_cntall", (bus.flitCountVector == '0), 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("arst_hold_valid", bus.validOutVector, 5'b00000);
        idle();
        reset = 1'b0;
        repeat (3) @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
